// File: rtl/cpu_pkg.sv
// Shared types and widths for the cpu pipeline control logic.
package cpu_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_EX  = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } hz_state_e;

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding comparator for one source register; EX beats MEM, x0 never forwards.
module fwd_unit
    import cpu_pkg::*;
#(
    parameter int unsigned AW = cpu_pkg::REG_AW
) (
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] ex_rd,
    input  logic          ex_reg_write,
    input  logic          ex_mem_read,
    input  logic [AW-1:0] mem_rd,
    input  logic          mem_reg_write,
    output fwd_sel_e      sel_c
);

    // A load in EX has no result yet, so only ALU results forward from EX.
    always_comb begin
        sel_c = FWD_RF;
        if (ex_reg_write && !ex_mem_read && (ex_rd != '0) && (ex_rd == rs)) begin
            sel_c = FWD_EX;
        end else if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
            sel_c = FWD_MEM;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing for the 5-stage core: stalls, flushes, forwarding
// selects and the ecall drain handshake.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW    = cpu_pkg::REG_AW,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [REG_AW-1:0] id_i_rs1,
    input  logic [REG_AW-1:0] id_i_rs2,
    input  logic              id_i_use_rs1,
    input  logic              id_i_use_rs2,
    input  logic              id_i_ecall,
    input  logic [REG_AW-1:0] ex_i_rd,
    input  logic              ex_i_reg_write,
    input  logic              ex_i_mem_read,
    input  logic              ex_i_branch_taken,
    input  logic [REG_AW-1:0] mem_i_rd,
    input  logic              mem_i_reg_write,
    output logic              o_stall_if,
    output logic              o_stall_id,
    output logic              o_flush_id,
    output logic              o_flush_ex,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic              o_ecall_ready
);

    hz_state_e        st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    fwd_sel_e         fwd_a_sel, fwd_b_sel;
    logic             load_use;

    fwd_unit #(.AW(REG_AW)) u_fwd_a (
        .rs            (id_i_rs1),
        .ex_rd         (ex_i_rd),
        .ex_reg_write  (ex_i_reg_write),
        .ex_mem_read   (ex_i_mem_read),
        .mem_rd        (mem_i_rd),
        .mem_reg_write (mem_i_reg_write),
        .sel_c         (fwd_a_sel)
    );

    fwd_unit #(.AW(REG_AW)) u_fwd_b (
        .rs            (id_i_rs2),
        .ex_rd         (ex_i_rd),
        .ex_reg_write  (ex_i_reg_write),
        .ex_mem_read   (ex_i_mem_read),
        .mem_rd        (mem_i_rd),
        .mem_reg_write (mem_i_reg_write),
        .sel_c         (fwd_b_sel)
    );

    // Load in EX whose destination is read by the instruction in ID.
    assign load_use = ex_i_mem_read && ex_i_reg_write && (ex_i_rd != '0) &&
                      ((id_i_use_rs1 && (id_i_rs1 == ex_i_rd)) ||
                       (id_i_use_rs2 && (id_i_rs2 == ex_i_rd)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st  <= IDLE;
            cnt <= '0;
        end else begin
            st  <= st_n;
            cnt <= cnt_n;
        end
    end

    // Next state: dropping i_start always parks the controller, even mid-drain.
    always_comb begin
        st_n  = st;
        cnt_n = cnt;
        if (!i_start) begin
            st_n  = IDLE;
            cnt_n = '0;
        end else begin
            case (st)
                IDLE:  st_n = RUN;
                RUN: begin
                    if (!ex_i_branch_taken && !load_use && id_i_ecall) begin
                        st_n  = DRAIN;
                        cnt_n = CNT_W'(DRAIN_CYC - 1);
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        st_n = DONE;
                    end else begin
                        cnt_n = cnt - CNT_W'(1);
                    end
                end
                DONE:    st_n = RUN;
                default: st_n = IDLE;
            endcase
        end
    end

    // Outputs: branch squash outranks load-use, which outranks ecall entry.
    always_comb begin
        o_stall_if    = 1'b0;
        o_stall_id    = 1'b0;
        o_flush_id    = 1'b0;
        o_flush_ex    = 1'b0;
        o_ecall_ready = 1'b0;
        o_fwd_a       = i_rst_n ? 2'(fwd_a_sel) : 2'(FWD_RF);
        o_fwd_b       = i_rst_n ? 2'(fwd_b_sel) : 2'(FWD_RF);
        case (st)
            IDLE: begin
                o_stall_if = 1'b1;
                o_stall_id = 1'b1;
            end
            RUN: begin
                if (ex_i_branch_taken) begin
                    o_flush_id = 1'b1;
                    o_flush_ex = 1'b1;
                end else if (load_use || id_i_ecall) begin
                    o_stall_if = 1'b1;
                    o_stall_id = 1'b1;
                    o_flush_ex = 1'b1;
                end
            end
            DRAIN: begin
                o_stall_if = 1'b1;
                o_stall_id = 1'b1;
                o_flush_ex = 1'b1;
            end
            DONE: begin
                o_flush_id    = 1'b1;
                o_ecall_ready = 1'b1;
            end
            default: begin
                o_stall_if = 1'b1;
                o_stall_id = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected output words are queued as
// stimulus is applied and compared mid-cycle.
module tb_hazard_ctrl;

    typedef struct packed {
        logic       stall_if;
        logic       stall_id;
        logic       flush_id;
        logic       flush_ex;
        logic [1:0] fwd_a;
        logic [1:0] fwd_b;
        logic       ecall_ready;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_use_rs1, id_use_rs2, id_ecall;
    logic       ex_reg_write, ex_mem_read, ex_branch_taken, mem_reg_write;
    logic       stall_if, stall_id, flush_id, flush_ex, ecall_ready;
    logic [1:0] fwd_a, fwd_b;

    out_t obs;
    out_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .DRAIN_CYC(3)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (start),
        .id_i_rs1          (id_rs1),
        .id_i_rs2          (id_rs2),
        .id_i_use_rs1      (id_use_rs1),
        .id_i_use_rs2      (id_use_rs2),
        .id_i_ecall        (id_ecall),
        .ex_i_rd           (ex_rd),
        .ex_i_reg_write    (ex_reg_write),
        .ex_i_mem_read     (ex_mem_read),
        .ex_i_branch_taken (ex_branch_taken),
        .mem_i_rd          (mem_rd),
        .mem_i_reg_write   (mem_reg_write),
        .o_stall_if        (stall_if),
        .o_stall_id        (stall_id),
        .o_flush_id        (flush_id),
        .o_flush_ex        (flush_ex),
        .o_fwd_a           (fwd_a),
        .o_fwd_b           (fwd_b),
        .o_ecall_ready     (ecall_ready)
    );

    assign obs = {stall_if, stall_id, flush_id, flush_ex, fwd_a, fwd_b, ecall_ready};

    function automatic out_t mk(input int si, input int sd, input int fi, input int fe,
                                input int fa, input int fb, input int er);
        mk = {1'(si), 1'(sd), 1'(fi), 1'(fe), 2'(fa), 2'(fb), 1'(er)};
    endfunction

    task automatic set_id(input int rs1, input int rs2, input int u1, input int u2, input int ec);
        id_rs1     = 5'(rs1);
        id_rs2     = 5'(rs2);
        id_use_rs1 = 1'(u1);
        id_use_rs2 = 1'(u2);
        id_ecall   = 1'(ec);
    endtask

    task automatic set_ex(input int rd, input int rw, input int mr, input int br);
        ex_rd           = 5'(rd);
        ex_reg_write    = 1'(rw);
        ex_mem_read     = 1'(mr);
        ex_branch_taken = 1'(br);
    endtask

    task automatic set_mem(input int rd, input int rw);
        mem_rd        = 5'(rd);
        mem_reg_write = 1'(rw);
    endtask

    task automatic clr();
        set_id(0, 0, 0, 0, 0);
        set_ex(0, 0, 0, 0);
        set_mem(0, 0);
    endtask

    task automatic test_reset();
        out_t w;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            case (i)
                0: begin
                    rst_n = 1'b0; start = 1'b0;
                    clr(); set_ex(3, 1, 0, 0); set_id(3, 0, 1, 0, 0);
                    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
                end
                1: begin
                    rst_n = 1'b1;
                    exp_q.push_back(mk(1, 1, 0, 0, 2, 0, 0));
                end
                6: begin
                    clr(); start = 1'b1;
                    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
                end
                7: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                default: begin
                    clr();
                    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
                end
            endcase
            #1;
            w = exp_q.pop_front();
            n_checks++;
            if (obs !== w) begin
                n_errors++;
                $display("FAIL reset[%0d]: got %b want %b", i, obs, w);
            end
        end
    endtask

    task automatic test_load_use();
        out_t w;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clr();
            case (i)
                0: begin set_ex(5, 1, 1, 0); set_id(5, 0, 1, 0, 0); exp_q.push_back(mk(1, 1, 0, 1, 0, 0, 0)); end
                1: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
                2: begin set_ex(0, 1, 1, 0); set_id(0, 0, 1, 0, 0); exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
                3: begin set_ex(7, 1, 1, 0); set_id(0, 7, 0, 1, 0); exp_q.push_back(mk(1, 1, 0, 1, 0, 0, 0)); end
                4: begin set_ex(5, 1, 1, 0); set_id(5, 0, 0, 0, 0); exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
                default: begin set_ex(5, 1, 0, 0); set_id(5, 0, 1, 0, 0); exp_q.push_back(mk(0, 0, 0, 0, 2, 0, 0)); end
            endcase
            #1;
            w = exp_q.pop_front();
            n_checks++;
            if (obs !== w) begin
                n_errors++;
                $display("FAIL load_use[%0d]: got %b want %b", i, obs, w);
            end
        end
    endtask

    task automatic test_forwarding();
        out_t w;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clr();
            case (i)
                0: begin set_ex(3, 1, 0, 0); set_mem(3, 1); set_id(3, 3, 1, 1, 0); exp_q.push_back(mk(0, 0, 0, 0, 2, 2, 0)); end
                1: begin set_ex(3, 0, 0, 0); set_mem(3, 1); set_id(3, 3, 1, 1, 0); exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0)); end
                2: begin set_ex(0, 1, 0, 0); set_mem(0, 1); set_id(3, 3, 1, 1, 0); exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
                3: begin set_ex(0, 1, 0, 0); set_mem(0, 1); set_id(0, 0, 1, 1, 0); exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); end
                4: begin set_ex(4, 1, 1, 0); set_mem(4, 1); set_id(4, 9, 0, 0, 0); exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0)); end
                5: begin set_ex(6, 1, 0, 0); set_mem(8, 1); set_id(6, 8, 1, 1, 0); exp_q.push_back(mk(0, 0, 0, 0, 2, 1, 0)); end
                default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            endcase
            #1;
            w = exp_q.pop_front();
            n_checks++;
            if (obs !== w) begin
                n_errors++;
                $display("FAIL forwarding[%0d]: got %b want %b", i, obs, w);
            end
        end
    endtask

    task automatic test_ecall();
        out_t w;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clr();
            case (i)
                0, 1, 3: begin set_id(0, 0, 0, 0, 1); exp_q.push_back(mk(1, 1, 0, 1, 0, 0, 0)); end
                2: begin set_id(0, 0, 0, 0, 1); set_ex(0, 0, 0, 1); exp_q.push_back(mk(1, 1, 0, 1, 0, 0, 0)); end
                4: exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 1));
                default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            endcase
            #1;
            w = exp_q.pop_front();
            n_checks++;
            if (obs !== w) begin
                n_errors++;
                $display("FAIL ecall[%0d]: got %b want %b", i, obs, w);
            end
        end
    endtask

    task automatic test_ecall_after_load_use();
        out_t w;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clr();
            case (i)
                0: begin set_id(5, 0, 1, 0, 1); set_ex(5, 1, 1, 0); exp_q.push_back(mk(1, 1, 0, 1, 0, 0, 0)); end
                1: begin set_id(5, 0, 1, 0, 1); set_mem(5, 1); exp_q.push_back(mk(1, 1, 0, 1, 1, 0, 0)); end
                2, 3, 4: begin set_id(5, 0, 1, 0, 1); exp_q.push_back(mk(1, 1, 0, 1, 0, 0, 0)); end
                5: exp_q.push_back(mk(0, 0, 1, 0, 0, 0, 1));
                default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            endcase
            #1;
            w = exp_q.pop_front();
            n_checks++;
            if (obs !== w) begin
                n_errors++;
                $display("FAIL ecall_after_load_use[%0d]: got %b want %b", i, obs, w);
            end
        end
    endtask

    task automatic test_branch();
        out_t w;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clr();
            case (i)
                0: begin set_id(0, 0, 0, 0, 1); set_ex(0, 0, 0, 1); exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 0)); end
                2: begin set_id(5, 0, 1, 0, 0); set_ex(5, 1, 1, 1); exp_q.push_back(mk(0, 0, 1, 1, 0, 0, 0)); end
                default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            endcase
            #1;
            w = exp_q.pop_front();
            n_checks++;
            if (obs !== w) begin
                n_errors++;
                $display("FAIL branch[%0d]: got %b want %b", i, obs, w);
            end
        end
    endtask

    task automatic test_start_drop();
        out_t w;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clr();
            case (i)
                0, 1: begin set_id(0, 0, 0, 0, 1); exp_q.push_back(mk(1, 1, 0, 1, 0, 0, 0)); end
                2: begin set_id(0, 0, 0, 0, 1); start = 1'b0; exp_q.push_back(mk(1, 1, 0, 1, 0, 0, 0)); end
                3, 4: exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
                5: begin start = 1'b1; exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0)); end
                default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            endcase
            #1;
            w = exp_q.pop_front();
            n_checks++;
            if (obs !== w) begin
                n_errors++;
                $display("FAIL start_drop[%0d]: got %b want %b", i, obs, w);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        out_t w;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clr();
            case (i)
                0, 1: begin set_id(0, 0, 0, 0, 1); exp_q.push_back(mk(1, 1, 0, 1, 0, 0, 0)); end
                2, 3: begin
                    rst_n = 1'b0;
                    set_ex(3, 1, 0, 0); set_id(3, 0, 1, 0, 0);
                    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
                end
                4: begin rst_n = 1'b1; exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0)); end
                default: exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
            endcase
            #1;
            w = exp_q.pop_front();
            n_checks++;
            if (obs !== w) begin
                n_errors++;
                $display("FAIL reset_mid_drain[%0d]: got %b want %b", i, obs, w);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clr();
        test_reset();
        test_load_use();
        test_forwarding();
        test_ecall();
        test_ecall_after_load_use();
        test_branch();
        test_start_drop();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
